// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard controller
package pipe_pkg;
  localparam int REG_AW = 4;
  localparam int SRAM_WAIT_DEF = 5;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} sram_state_t;
  function automatic logic reg_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b, input logic en);
    return en & (a == b);
  endfunction
endpackage

// File: rtl/sram_wait_fsm.sv
// sram_wait_fsm: counts SRAM wait states for a MEM-stage access
module sram_wait_fsm
  import pipe_pkg::*;
#(
  parameter int SRAM_WAIT = SRAM_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic mem_stall,
  output logic mem_data_valid
);
  localparam logic [3:0] WLOAD = (SRAM_WAIT > 1) ? 4'(SRAM_WAIT - 2) : 4'd0;
  sram_state_t state;
  logic [3:0] wcnt;
  // IDLE -> ACCESS (counting) -> DONE for one cycle -> IDLE; DONE ignores mem_req
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt <= '0;
    end else begin
      case (state)
        IDLE: if (mem_req) begin
          state <= (SRAM_WAIT == 1) ? DONE : ACCESS;
          wcnt <= WLOAD;
        end
        ACCESS: if (wcnt == 4'd0) state <= DONE; else wcnt <= wcnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
  end
  // a fresh request stalls in the same cycle it shows up in IDLE
  always_comb begin
    mem_stall = (state == ACCESS) | ((state == IDLE) & mem_req);
    mem_data_valid = state == DONE;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: freeze/flush sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int SRAM_WAIT = SRAM_WAIT_DEF,
  parameter bit FORWARD_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_read,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic              mem_req,
  input  logic              branch_taken,
  output logic              pc_freeze,
  output logic              if_freeze,
  output logic              if_flush,
  output logic              id_flush,
  output logic              back_freeze,
  output logic              mem_data_valid,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic mem_stall, sram_valid, exe_hit, mem_hit, hazard;
  sram_wait_fsm #(.SRAM_WAIT(SRAM_WAIT)) u_fsm (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_stall(mem_stall),
    .mem_data_valid(sram_valid)
  );
  // with forwarding only a load in EXE cannot be bypassed in time
  always_comb begin
    exe_hit = exe_wb_en & (reg_match(id_src1, exe_dest, id_valid) | reg_match(id_src2, exe_dest, id_valid & id_two_src));
    mem_hit = mem_wb_en & (reg_match(id_src1, mem_dest, id_valid) | reg_match(id_src2, mem_dest, id_valid & id_two_src));
    hazard = FORWARD_EN ? exe_hit & exe_mem_read : exe_hit | mem_hit;
  end
  // priority: SRAM stall holds everything, then branch flush, then hazard bubble; reset forces all low
  always_comb begin
    pc_freeze = ~rst & (mem_stall | (~branch_taken & hazard));
    if_freeze = pc_freeze;
    back_freeze = ~rst & mem_stall;
    if_flush = ~rst & ~mem_stall & branch_taken;
    id_flush = ~rst & ~mem_stall & (branch_taken | hazard);
    mem_data_valid = ~rst & sram_valid;
  end
  // saturating count of cycles the PC was held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (pc_freeze && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench over two controller configurations
module tb_pipeline_hazard_ctrl;
  typedef struct packed {
    logic [3:0] s1, s2;
    logic two, valid;
    logic [3:0] ed;
    logic ewb, erd;
    logic [3:0] md;
    logic mwb, mreq, br;
  } in_t;
  typedef struct {
    string name;
    bit ca, cb;
    logic [5:0] ea, eb;
    logic [15:0] na, nb;
  } exp_t;
  localparam logic [5:0] O_IDLE = 6'b000000, O_MEM = 6'b110010, O_DONE = 6'b000001;
  localparam logic [5:0] O_HAZ = 6'b110100, O_BR = 6'b001100, O_BRDONE = 6'b001101;
  logic clk = 1'b0, rst;
  in_t in_a, in_b;
  logic [5:0] oa, ob;
  logic [15:0] cnt_a;
  logic [2:0] cnt_b;
  exp_t sb[$];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.SRAM_WAIT(5), .FORWARD_EN(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_src1(in_a.s1), .id_src2(in_a.s2), .id_two_src(in_a.two),
    .id_valid(in_a.valid), .exe_dest(in_a.ed), .exe_wb_en(in_a.ewb), .exe_mem_read(in_a.erd),
    .mem_dest(in_a.md), .mem_wb_en(in_a.mwb), .mem_req(in_a.mreq), .branch_taken(in_a.br),
    .pc_freeze(oa[5]), .if_freeze(oa[4]), .if_flush(oa[3]), .id_flush(oa[2]),
    .back_freeze(oa[1]), .mem_data_valid(oa[0]), .stall_cnt(cnt_a)
  );
  pipeline_hazard_ctrl #(.SRAM_WAIT(1), .FORWARD_EN(1'b0), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .id_src1(in_b.s1), .id_src2(in_b.s2), .id_two_src(in_b.two),
    .id_valid(in_b.valid), .exe_dest(in_b.ed), .exe_wb_en(in_b.ewb), .exe_mem_read(in_b.erd),
    .mem_dest(in_b.md), .mem_wb_en(in_b.mwb), .mem_req(in_b.mreq), .branch_taken(in_b.br),
    .pc_freeze(ob[5]), .if_freeze(ob[4]), .if_flush(ob[3]), .id_flush(ob[2]),
    .back_freeze(ob[1]), .mem_data_valid(ob[0]), .stall_cnt(cnt_b)
  );
  function automatic in_t mk(input logic [3:0] s1, input logic [3:0] s2, input logic two, input logic valid,
                             input logic [3:0] ed, input logic ewb, input logic erd,
                             input logic [3:0] md, input logic mwb, input logic mreq, input logic br);
    in_t v;
    v = '{s1, s2, two, valid, ed, ewb, erd, md, mwb, mreq, br};
    return v;
  endfunction
  task automatic step(input logic r, input in_t ia, input in_t ib, input string nm,
                      input bit ca, input logic [5:0] ea, input logic [15:0] na,
                      input bit cb, input logic [5:0] eb, input logic [15:0] nb);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    in_a = ia;
    in_b = ib;
    e = '{nm, ca, cb, ea, eb, na, nb};
    sb.push_back(e);
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.ca) begin
        checks++;
        if ({oa, cnt_a} !== {e.ea, e.na}) begin
          errors++;
          $display("FAIL %s dut_a: outs=%b cnt=%0d expected outs=%b cnt=%0d", e.name, oa, cnt_a, e.ea, e.na);
        end
      end
      if (e.cb) begin
        checks++;
        if ({ob, 13'd0, cnt_b} !== {e.eb, e.nb}) begin
          errors++;
          $display("FAIL %s dut_b: outs=%b cnt=%0d expected outs=%b cnt=%0d", e.name, ob, cnt_b, e.eb, e.nb);
        end
      end
    end
  end
  initial begin
    in_t z, ld, lu, ln, mm, rm, rm1, re, rv, bl, bh;
    z = '0;
    ld = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    lu = mk(3, 0, 0, 1, 3, 1, 1, 0, 0, 0, 0);
    ln = mk(3, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0);
    mm = mk(3, 0, 0, 1, 0, 0, 0, 3, 1, 0, 0);
    rm = mk(0, 7, 1, 1, 0, 0, 0, 7, 1, 0, 0);
    rm1 = mk(0, 7, 0, 1, 0, 0, 0, 7, 1, 0, 0);
    re = mk(4, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0);
    rv = mk(4, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    bl = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    bh = mk(3, 0, 0, 1, 3, 1, 1, 0, 0, 0, 1);
    rst = 1'b1;
    in_a = z;
    in_b = z;
    step(1, z, z, "reset", 1, O_IDLE, 0, 1, O_IDLE, 0);
    for (int k = 0; k < 5; k++) step(0, ld, z, "load_stall", 1, O_MEM, 16'(k), 0, O_IDLE, 0);
    step(0, ld, z, "load_done", 1, O_DONE, 5, 0, O_IDLE, 0);
    step(0, z, z, "load_after", 1, O_IDLE, 5, 1, O_IDLE, 0);
    step(0, z, ld, "b2b_0", 0, O_IDLE, 0, 1, O_MEM, 0);
    step(0, z, ld, "b2b_1", 0, O_IDLE, 0, 1, O_DONE, 1);
    step(0, z, ld, "b2b_2", 0, O_IDLE, 0, 1, O_MEM, 1);
    step(0, z, ld, "b2b_3", 0, O_IDLE, 0, 1, O_DONE, 2);
    step(0, z, z, "b2b_after", 0, O_IDLE, 0, 1, O_IDLE, 2);
    step(0, lu, z, "load_use", 1, O_HAZ, 5, 0, O_IDLE, 0);
    step(0, ln, z, "no_load_use", 1, O_IDLE, 6, 0, O_IDLE, 0);
    step(0, mm, z, "fwd_mem_match", 1, O_IDLE, 6, 0, O_IDLE, 0);
    step(0, z, rm, "raw_mem_src2", 0, O_IDLE, 0, 1, O_HAZ, 2);
    step(0, z, rm1, "raw_one_src", 0, O_IDLE, 0, 1, O_IDLE, 3);
    step(0, z, re, "raw_exe", 0, O_IDLE, 0, 1, O_HAZ, 3);
    step(0, z, rv, "raw_invalid", 0, O_IDLE, 0, 1, O_IDLE, 4);
    for (int k = 4; k < 9; k++) step(0, z, re, "sat", 0, O_IDLE, 0, 1, O_HAZ, 16'((k > 7) ? 7 : k));
    step(0, z, z, "sat_after", 0, O_IDLE, 0, 1, O_IDLE, 7);
    step(0, ld, z, "br_idle", 1, O_MEM, 6, 0, O_IDLE, 0);
    for (int k = 7; k < 11; k++) step(0, bl, z, "br_access", 1, O_MEM, 16'(k), 0, O_IDLE, 0);
    step(0, bl, z, "br_done", 1, O_BRDONE, 11, 0, O_IDLE, 0);
    step(0, z, z, "br_after", 1, O_IDLE, 11, 0, O_IDLE, 0);
    step(0, bh, z, "br_hazard", 1, O_BR, 11, 0, O_IDLE, 0);
    step(0, z, z, "br_hz_after", 1, O_IDLE, 11, 0, O_IDLE, 0);
    step(0, ld, z, "rm_idle", 1, O_MEM, 11, 0, O_IDLE, 0);
    step(0, ld, z, "rm_access1", 1, O_MEM, 12, 0, O_IDLE, 0);
    step(1, ld, z, "rm_reset", 1, O_IDLE, 0, 1, O_IDLE, 0);
    step(0, z, z, "rm_release", 1, O_IDLE, 0, 1, O_IDLE, 0);
    for (int k = 0; k < 5; k++) step(0, ld, z, "rl_stall", 1, O_MEM, 16'(k), 0, O_IDLE, 0);
    step(0, ld, z, "rl_done", 1, O_DONE, 5, 0, O_IDLE, 0);
    step(0, z, z, "rl_after", 1, O_IDLE, 5, 0, O_IDLE, 0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central freeze/flush sequencer for the 5-stage ARM pipeline.
- Drives the freeze/flush inputs of the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers.
- Resolves three stall sources: RAW data hazards (with or without forwarding), taken-branch flushes, and multi-cycle SRAM accesses in MEM.
- The SRAM wait states are counted by an internal FSM.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- SRAM_WAIT, 5, total stall cycles per MEM load/store; legal range 1..15.
- FORWARD_EN, 1, 1 = forwarding unit present, so only load-use stalls; 0 = stall on any RAW match.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_src1  in  4  ID-stage Rn.
- id_src2  in  4  ID-stage Rm/Rd (store source).
- id_two_src  in  1  id_src2 is a real operand.
- id_valid  in  1  ID holds a real instruction.
- exe_dest  in  4  EXE-stage destination register.
- exe_wb_en  in  1  EXE instruction writes back.
- exe_mem_read  in  1  EXE instruction is a load.
- mem_dest  in  4  MEM-stage destination register.
- mem_wb_en  in  1  MEM instruction writes back.
- mem_req  in  1  MEM instruction is a load or store.
- branch_taken  in  1  EXE resolved a taken branch.
- pc_freeze  out  1  hold the PC.
- if_freeze  out  1  hold the IF/ID register.
- if_flush  out  1  clear the IF/ID register.
- id_flush  out  1  load a bubble into ID/EXE.
- back_freeze  out  1  hold ID/EXE, EXE/MEM and MEM/WB.
- mem_data_valid  out  1  SRAM read data is valid this cycle.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (async, rst=1): FSM goes to IDLE; counters clear; all outputs 0.
- Reset mid-access aborts the access; no DONE pulse is produced.

SRAM FSM (states IDLE, ACCESS, DONE):
- IDLE & mem_req: mem_stall=1.
  - SRAM_WAIT==1 -> DONE.
  - Otherwise -> ACCESS, with wcnt loaded to SRAM_WAIT-2.
- ACCESS: mem_stall=1.
  - wcnt==0 -> DONE.
  - Otherwise wcnt decrements.
- DONE: mem_stall=0 and mem_data_valid=1 for exactly 1 cycle; -> IDLE unconditionally.
  - mem_req still high in DONE is the same instruction and must not restart an access.
- Result: every access stalls exactly SRAM_WAIT cycles, then the pipeline advances at the end of DONE.
- Back-to-back accesses: IDLE is re-entered one cycle after DONE, and the new MEM instruction stalls immediately.

Hazard detection (combinational, registered FSM only):
- match1 = id_valid & (id_src1 == dest).
- match2 = id_valid & id_two_src & (id_src2 == dest).
- FORWARD_EN=0: hazard = (match vs exe_dest & exe_wb_en) | (match vs mem_dest & mem_wb_en).
- FORWARD_EN=1: hazard = match vs exe_dest & exe_wb_en & exe_mem_read.

Output priority:
1. mem_stall: pc_freeze=if_freeze=back_freeze=1; if_flush=id_flush=0. A branch or hazard is held, because EXE is frozen, and is acted on after the stall.
2. branch_taken: if_flush=id_flush=1; hazard ignored; no freezes.
3. hazard: pc_freeze=if_freeze=1, id_flush=1 (bubble).
4. Otherwise all 0.

Other rules:
- Freeze and flush are never both asserted on the same register.
- stall_cnt increments on every cycle where pc_freeze=1, and saturates at all-ones (no wrap).

Decomposition:
- Shared package pipe_pkg holds:
  - FSM state enum (IDLE=0, ACCESS=1, DONE=2);
  - register-address width constant REG_AW=4;
  - default SRAM_WAIT.
- One natural sub-module, sram_wait_fsm (FSM + wcnt, outputs mem_stall, mem_data_valid).
- Hazard compare and priority logic stay in the top.

Test Plan:
- Reset mid-access: mem_req=1, assert rst during ACCESS cycle 2 -> all outputs 0 immediately (async); after release, FSM is IDLE and stall_cnt=0.
- SRAM_WAIT=5, single load: mem_req=1 from cycle 0 -> back_freeze=1 for cycles 0..4; cycle 5 mem_data_valid=1 and back_freeze=0; stall_cnt=5.
- SRAM_WAIT=1, back-to-back stores: mem_req high for 4 cycles -> stall pattern 1,0,1,0; mem_data_valid pattern 0,1,0,1.
- FORWARD_EN=1 load-use: exe_dest=3, exe_wb_en=1, exe_mem_read=1, id_src1=3 -> one cycle with pc_freeze=if_freeze=id_flush=1. Same case with exe_mem_read=0 -> no stall.
- FORWARD_EN=0: mem_dest=7, mem_wb_en=1, id_two_src=1, id_src2=7 -> hazard stall. Same case with id_two_src=0 -> none.
- Branch during SRAM stall: branch_taken=1 while state=ACCESS -> if_flush=0 until DONE; in DONE if_flush=id_flush=1. Branch plus simultaneous hazard -> flushes only, pc_freeze=0.
